// File: rtl/hypot_rr_sched.sv
// Round-robin scheduler sharing one iterative floor(sqrt(x*x + y*y)) engine among NREQ requesters.
// A grant latches operands, one cycle squares, W+1 cycles resolve the root bit-serially, the result is held until consumed.
module hypot_rr_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_x,
    input  logic [NREQ*W-1:0]   req_y,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W:0]          rsp_mag,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    localparam int unsigned SW = 2 * W + 1;
    localparam int unsigned PW = 2 * W + 2;
    localparam int unsigned BW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SQUARE,
        S_ROOT,
        S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, y_q;
    logic [IDW-1:0] id_q, last_q;
    logic [SW-1:0]  sum_q;
    logic [W:0]     root_q;
    logic [BW-1:0]  bit_q;

    logic [W-1:0]   xs [NREQ];
    logic [W-1:0]   ys [NREQ];
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] idx;
    logic           found;
    logic           grant_ok;

    logic [SW-1:0]  xe, ye, sq_sum;
    logic [W:0]     trial, root_nxt;
    logic [PW-1:0]  trial_sq;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign xs[g] = req_x[g*W +: W];
        assign ys[g] = req_y[g*W +: W];
    end

    // Round-robin search: nearest valid requester after the last winner.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDW'((32'(last_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = idx;
            end
        end
    end

    assign grant_ok  = (state_q == S_IDLE) && ena && found;
    assign req_ready = grant_ok ? (NREQ'(1) << grant_id) : '0;

    // Full-width square sum and trial square so nothing wraps at the top of the range.
    assign xe       = SW'(x_q);
    assign ye       = SW'(y_q);
    assign sq_sum   = xe * xe + ye * ye;
    assign trial    = root_q | ((W + 1)'(1) << bit_q);
    assign trial_sq = PW'(trial) * PW'(trial);
    assign root_nxt = (trial_sq <= PW'(sum_q)) ? trial : root_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                S_IDLE:   if (found) state_d = S_SQUARE;
                S_SQUARE: state_d = S_ROOT;
                S_ROOT:   if (bit_q == '0) state_d = S_RESP;
                S_RESP:   if (rsp_ready) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
            last_q    <= IDW'(NREQ - 1);
            sum_q     <= '0;
            root_q    <= '0;
            bit_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_mag   <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else if (ena) begin
            busy <= (state_d != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        x_q    <= xs[grant_id];
                        y_q    <= ys[grant_id];
                        id_q   <= grant_id;
                        last_q <= grant_id;
                    end
                end
                S_SQUARE: begin
                    sum_q  <= sq_sum;
                    root_q <= '0;
                    bit_q  <= BW'(W);
                end
                S_ROOT: begin
                    root_q <= root_nxt;
                    if (bit_q != '0) begin
                        bit_q <= bit_q - BW'(1);
                    end else begin
                        rsp_mag   <= root_nxt;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_rr_sched.sv
// Directed bench for hypot_rr_sched: latency, boundary results, round-robin order, hold, enable and reset abort.
module tb_hypot_rr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_mag;
    logic [1:0]  rsp_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    hypot_rr_sched #(.NREQ(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_mag   (rsp_mag),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from a single requester; returns result, id and cycles from handshake to rsp_valid.
    task automatic do_txn(input int id, input logic [7:0] x, input logic [7:0] y,
                          output logic [8:0] mag, output logic [1:0] rid, output int lat);
        int n;
        req_x[id*8 +: 8] = x;
        req_y[id*8 +: 8] = y;
        req_valid = 4'(1) << id;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 4'b0;
        req_x = ~req_x;
        req_y = ~req_y;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        mag = rsp_mag;
        rid = rsp_id;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        req_valid = 4'b0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
        total++; if (rsp_mag !== 9'd0) begin bad++; $display("FAIL reset_rsp_mag got=%0d want=0", rsp_mag); end
        total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
        rst_n = 1'b1;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b want=0", busy); end
    endtask

    task automatic test_latency();
        req_x[7:0] = 8'd3;
        req_y[7:0] = 8'd4;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL lat_grant got=%b want=0001", req_ready); end
        tick();
        req_valid = 4'b0;
        req_x[7:0] = 8'd99;
        req_y[7:0] = 8'd77;
        for (int c = 1; c <= 11; c++) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy cycle=%0d got=%0b want=1", c, busy); end
            total++; if (rsp_valid !== (c == 11)) begin bad++; $display("FAIL lat_rsp_valid cycle=%0d got=%0b want=%0b", c, rsp_valid, (c == 11)); end
            if (c == 11) begin
                total++; if (rsp_mag !== 9'd5) begin bad++; $display("FAIL lat_mag got=%0d want=5", rsp_mag); end
                total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL lat_id got=%0d want=0", rsp_id); end
            end
            tick();
        end
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lat_after_valid got=%0b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_after_busy got=%0b want=0", busy); end
        total++; if (rsp_mag !== 9'd5) begin bad++; $display("FAIL lat_after_mag_hold got=%0d want=5", rsp_mag); end
    endtask

    task automatic test_boundary();
        logic [7:0] xv [4];
        logic [7:0] yv [4];
        logic [8:0] ev [4];
        logic [8:0] mag;
        logic [1:0] rid;
        int lat;
        xv[0] = 8'd255; yv[0] = 8'd255; ev[0] = 9'd360;
        xv[1] = 8'd0;   yv[1] = 8'd0;   ev[1] = 9'd0;
        xv[2] = 8'd1;   yv[2] = 8'd1;   ev[2] = 9'd1;
        xv[3] = 8'd0;   yv[3] = 8'd200; ev[3] = 9'd200;
        for (int i = 0; i < 4; i++) begin
            do_txn(3, xv[i], yv[i], mag, rid, lat);
            total++; if (mag !== ev[i]) begin bad++; $display("FAIL bound_mag x=%0d y=%0d got=%0d want=%0d", xv[i], yv[i], mag, ev[i]); end
            total++; if (rid !== 2'd3) begin bad++; $display("FAIL bound_id got=%0d want=3", rid); end
            total++; if (lat !== 11) begin bad++; $display("FAIL bound_latency got=%0d want=11", lat); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] grants [6];
        logic [1:0] ids [6];
        logic [8:0] mags [6];
        logic [3:0] eg [6];
        logic [1:0] ei [6];
        logic [8:0] em [6];
        int ngr, nrsp, cyc;
        eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100; eg[3] = 4'b1000; eg[4] = 4'b0001; eg[5] = 4'b0010;
        ei[0] = 2'd0; ei[1] = 2'd1; ei[2] = 2'd2; ei[3] = 2'd3; ei[4] = 2'd0; ei[5] = 2'd1;
        em[0] = 9'd5; em[1] = 9'd13; em[2] = 9'd10; em[3] = 9'd360; em[4] = 9'd5; em[5] = 9'd13;
        rst_n = 1'b0;
        req_x = {8'd255, 8'd6, 8'd5, 8'd3};
        req_y = {8'd255, 8'd8, 8'd12, 8'd4};
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        ngr = 0;
        nrsp = 0;
        cyc = 0;
        while (nrsp < 6 && cyc < 200) begin
            if (req_ready !== 4'b0 && ngr < 6) begin grants[ngr] = req_ready; ngr++; end
            if (rsp_valid === 1'b1) begin ids[nrsp] = rsp_id; mags[nrsp] = rsp_mag; nrsp++; end
            tick();
            cyc++;
        end
        req_valid = 4'b0;
        tick();
        rsp_ready = 1'b0;
        total++; if (nrsp !== 6) begin bad++; $display("FAIL rr_resp_count got=%0d want=6", nrsp); end
        for (int i = 0; i < 6; i++) begin
            if (i < ngr) begin
                total++; if (grants[i] !== eg[i]) begin bad++; $display("FAIL rr_grant n=%0d got=%b want=%b", i, grants[i], eg[i]); end
            end
            if (i < nrsp) begin
                total++; if (ids[i] !== ei[i]) begin bad++; $display("FAIL rr_id n=%0d got=%0d want=%0d", i, ids[i], ei[i]); end
                total++; if (mags[i] !== em[i]) begin bad++; $display("FAIL rr_mag n=%0d got=%0d want=%0d", i, mags[i], em[i]); end
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        req_x[15:8] = 8'd8;
        req_y[15:8] = 8'd15;
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        lat = 0;
        while (req_ready !== 4'b0010 && lat < 20) begin tick(); lat++; end
        tick();
        lat = 1;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        total++; if (lat !== 11) begin bad++; $display("FAIL hold_latency got=%0d want=11", lat); end
        for (int c = 0; c < 5; c++) begin
            total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d got=%0b want=1", c, rsp_valid); end
            total++; if (rsp_mag !== 9'd17) begin bad++; $display("FAIL hold_mag c=%0d got=%0d want=17", c, rsp_mag); end
            total++; if (rsp_id !== 2'd1) begin bad++; $display("FAIL hold_id c=%0d got=%0d want=1", c, rsp_id); end
            total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL hold_req_ready c=%0d got=%b want=0000", c, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL hold_regrant got=%b want=0010", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL hold_cleared got=%0b want=0", rsp_valid); end
        total++; if (rsp_mag !== 9'd17) begin bad++; $display("FAIL hold_mag_after got=%0d want=17", rsp_mag); end
        req_valid = 4'b0;
        tick();
    endtask

    task automatic test_enable();
        int lat;
        req_x[7:0] = 8'd20;
        req_y[7:0] = 8'd21;
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        lat = 0;
        while (req_ready !== 4'b0001 && lat < 20) begin tick(); lat++; end
        tick();
        req_valid = 4'b0;
        lat = 1;
        while (lat < 40) begin
            if (lat == 4) ena = 1'b0;
            if (lat == 7) ena = 1'b1;
            if (rsp_valid === 1'b1) break;
            tick();
            lat++;
        end
        total++; if (lat !== 14) begin bad++; $display("FAIL ena_latency got=%0d want=14", lat); end
        total++; if (rsp_mag !== 9'd29) begin bad++; $display("FAIL ena_mag got=%0d want=29", rsp_mag); end
        ena = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL ena_req_ready got=%b want=0000", req_ready); end
        tick();
        tick();
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL ena_rsp_frozen got=%0b want=1", rsp_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ena_busy_frozen got=%0b want=1", busy); end
        ena = 1'b1;
        tick();
        req_valid = 4'b0;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ena_rsp_consumed got=%0b want=0", rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [8:0] mag;
        logic [1:0] rid;
        int lat;
        req_x[7:0] = 8'd3;
        req_y[7:0] = 8'd4;
        req_valid = 4'b0001;
        #1;
        lat = 0;
        while (req_ready !== 4'b0001 && lat < 20) begin tick(); lat++; end
        tick();
        req_valid = 4'b0;
        repeat (5) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%0b want=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b want=0", busy); end
        total++; if (rsp_mag !== 9'd0) begin bad++; $display("FAIL rst_mid_mag got=%0d want=0", rsp_mag); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_discard c=%0d got=%0b want=0", c, rsp_valid); end
        end
        do_txn(2, 8'd6, 8'd8, mag, rid, lat);
        total++; if (mag !== 9'd10) begin bad++; $display("FAIL rst_mid_mag_after got=%0d want=10", mag); end
        total++; if (rid !== 2'd2) begin bad++; $display("FAIL rst_mid_id_after got=%0d want=2", rid); end
        total++; if (lat !== 11) begin bad++; $display("FAIL rst_mid_latency got=%0d want=11", lat); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_boundary();
        test_round_robin();
        test_hold();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
